// File: rtl/multi_timer_pkg.sv
// Shared register map and control-bit layout for the multi_timer block.
package multi_timer_pkg;

  localparam logic [7:0] OFF_COUNT   = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_IRQID   = 8'h08;
  localparam logic [7:0] OFF_CH_BASE = 8'h10;
  localparam logic [7:0] CH_STRIDE   = 8'h10;

  localparam logic [3:0] OFF_CMP  = 4'h0;
  localparam logic [3:0] OFF_PER  = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IE       = 2;
  localparam int unsigned CTRL_W        = 3;

  function automatic logic [7:0] ch_base(input int unsigned idx);
    return OFF_CH_BASE + 8'(idx) * CH_STRIDE;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare channel: COMPARE/PERIOD/CTRL registers, match detection and pending flag.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             we_cmp_i,
  input  logic             we_per_i,
  input  logic             we_ctrl_i,
  input  logic             clr_i,
  input  logic [3:0]       reg_off_i,
  output logic             fire_o,
  output logic             pending_o,
  output logic             ie_o,
  output logic [31:0]      rdata_o
);

  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              pending_q, pending_d;

  assign fire_o    = ctrl_q[CTRL_EN] && (count_i == cmp_q);
  assign pending_o = pending_q;
  assign ie_o      = ctrl_q[CTRL_IE];

  always_comb begin
    cmp_d  = cmp_q;
    per_d  = per_q;
    ctrl_d = ctrl_q;
    if (fire_o) begin
      if (ctrl_q[CTRL_PERIODIC]) begin
        cmp_d = cmp_q + per_q;
      end else begin
        ctrl_d[CTRL_EN] = 1'b0;
      end
    end
    // Software writes are applied last so they override fire side effects.
    if (we_cmp_i)  cmp_d  = wdata_i;
    if (we_per_i)  per_d  = wdata_i;
    if (we_ctrl_i) ctrl_d = wdata_i[CTRL_W-1:0];
    pending_d = fire_o | (pending_q & ~clr_i);
  end

  always_comb begin
    rdata_o = '0;
    case (reg_off_i)
      OFF_CMP:  rdata_o = 32'(cmp_q);
      OFF_PER:  rdata_o = 32'(per_q);
      OFF_CTRL: rdata_o = 32'(ctrl_q);
      default:  rdata_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmp_q     <= '1;
      per_q     <= '0;
      ctrl_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      per_q     <= per_d;
      ctrl_q    <= ctrl_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped multi-channel interrupt timer: shared free-running counter, address decode,
// read mux and lowest-index interrupt priority encoder.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic [31:0]       wr_data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       rd_data,
  output logic              hit,
  output logic              irq,
  output logic [2:0]        irq_id,
  output logic [NUM_CH-1:0] pending
);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        word_off;
  logic              wr_en;
  logic [NUM_CH-1:0] status_clr;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] ie;
  logic [NUM_CH-1:0] unused_fire;
  logic [31:0]       ch_rd [NUM_CH];
  logic [31:0]       rd_mux;
  logic              unused_bits;

  assign word_off    = {address[7:2], 2'b00};
  assign hit         = (address[31:8] == BASE_ADDR[31:8]);
  assign wr_en       = MemWrite & hit;
  assign status_clr  = (wr_en && word_off == OFF_STATUS) ? wr_data[NUM_CH-1:0] : '0;
  assign unused_bits = ^{address[1:0], wr_data};

  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (wr_en && word_off == OFF_COUNT) begin
      count_d = wr_data[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [7:0] ChBase = ch_base(i);

    assign ch_sel[i] = (word_off[7:4] == ChBase[7:4]);

    timer_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk_i     (clk),
      .reset_i   (reset),
      .count_i   (count_q),
      .wdata_i   (wr_data[CNT_W-1:0]),
      .we_cmp_i  (wr_en && ch_sel[i] && word_off[3:0] == OFF_CMP),
      .we_per_i  (wr_en && ch_sel[i] && word_off[3:0] == OFF_PER),
      .we_ctrl_i (wr_en && ch_sel[i] && word_off[3:0] == OFF_CTRL),
      .clr_i     (status_clr[i]),
      .reg_off_i (word_off[3:0]),
      .fire_o    (unused_fire[i]),
      .pending_o (pending[i]),
      .ie_o      (ie[i]),
      .rdata_o   (ch_rd[i])
    );
  end

  // Scan from the top down so the lowest enabled pending channel wins.
  always_comb begin
    irq    = 1'b0;
    irq_id = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (pending[i] && ie[i]) begin
        irq    = 1'b1;
        irq_id = 3'(i);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (word_off)
      OFF_COUNT:  rd_mux = 32'(count_q);
      OFF_STATUS: rd_mux = 32'(pending);
      OFF_IRQID:  rd_mux = 32'(irq_id);
      default: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (ch_sel[i]) rd_mux = ch_rd[i];
        end
      end
    endcase
  end

  assign rd_data = (hit && MemRead) ? rd_mux : '0;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: a 32-bit counter build and an 8-bit counter build on a
// shared bus.
module tb_multi_timer;

  localparam logic [31:0] Base = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, wr_data;
  logic        MemRead, MemWrite;

  logic [31:0] rd_data, rd_data8;
  logic        hit, hit8, irq, irq8;
  logic [2:0]  irq_id, irq_id8;
  logic [3:0]  pending, pending8;

  always #5 clk = ~clk;

  multi_timer #(
    .NUM_CH(4), .CNT_W(32), .BASE_ADDR(Base)
  ) u_dut (
    .clk(clk), .reset(reset), .address(address), .wr_data(wr_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .rd_data(rd_data), .hit(hit),
    .irq(irq), .irq_id(irq_id), .pending(pending)
  );

  multi_timer #(
    .NUM_CH(4), .CNT_W(8), .BASE_ADDR(Base)
  ) u_dut8 (
    .clk(clk), .reset(reset), .address(address), .wr_data(wr_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .rd_data(rd_data8), .hit(hit8),
    .irq(irq8), .irq_id(irq_id8), .pending(pending8)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    e = sb_q.pop_front();
    check_val(e.tag, act, e.val);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] data);
    address  = Base | 32'(off);
    wr_data  = data;
    MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [7:0] off, input logic [31:0] exp,
                        input bit narrow);
    address = Base | 32'(off);
    MemRead = 1'b1;
    sb_push(tag, exp);
    #1;
    sb_pop(narrow ? rd_data8 : rd_data);
    MemRead = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] pend, input logic irq_e,
                           input logic [2:0] id_e, input bit narrow);
    sb_push({tag, "_pend"}, 32'(pend));
    sb_push({tag, "_irq"}, 32'(irq_e));
    sb_push({tag, "_id"}, 32'(id_e));
    #1;
    sb_pop(narrow ? 32'(pending8) : 32'(pending));
    sb_pop(narrow ? 32'(irq8) : 32'(irq));
    sb_pop(narrow ? 32'(irq_id8) : 32'(irq_id));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset    = 1'b1;
    address  = '0;
    wr_data  = '0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    tick(3);
    reset = 1'b0;

    // Reset state and free-running count.
    chk_state("rst", 4'h0, 1'b0, 3'd0, 1'b0);
    bus_rd("rst_count", 8'h00, 32'd0, 1'b0);
    tick(4);
    bus_rd("count_plus5", 8'h00, 32'd5, 1'b0);
    bus_rd("rst_cmp0", 8'h10, 32'hFFFF_FFFF, 1'b0);
    bus_rd("rst_cmp0_w8", 8'h10, 32'h0000_00FF, 1'b1);
    bus_rd("rst_ctrl3", 8'h48, 32'd0, 1'b0);

    // One-shot channel 0: rises 11 cycles after the COUNT write edge.
    bus_wr(8'h00, 32'd100);
    bus_wr(8'h10, 32'd110);
    bus_wr(8'h18, 32'h5);
    tick(8);
    chk_state("os_before", 4'h0, 1'b0, 3'd0, 1'b0);
    tick(1);
    chk_state("os_fire", 4'h1, 1'b1, 3'd0, 1'b0);
    bus_rd("os_ctrl", 8'h18, 32'h4, 1'b0);
    bus_wr(8'h04, 32'h1);
    chk_state("os_ack", 4'h0, 1'b0, 3'd0, 1'b0);

    // Periodic channel 1: fires at 50, 70, 90.
    bus_wr(8'h24, 32'd20);
    bus_wr(8'h20, 32'd50);
    bus_wr(8'h28, 32'h7);
    bus_wr(8'h00, 32'd0);
    tick(50);
    chk_state("per_pre50", 4'h0, 1'b0, 3'd0, 1'b0);
    tick(1);
    chk_state("per_fire50", 4'h2, 1'b1, 3'd1, 1'b0);
    bus_wr(8'h04, 32'h2);
    chk_state("per_ack50", 4'h0, 1'b0, 3'd0, 1'b0);
    bus_rd("per_cmp70", 8'h20, 32'd70, 1'b0);
    tick(17);
    chk_state("per_pre70", 4'h0, 1'b0, 3'd0, 1'b0);
    tick(1);
    chk_state("per_fire70", 4'h2, 1'b1, 3'd1, 1'b0);
    bus_wr(8'h04, 32'h2);
    tick(18);
    chk_state("per_pre90", 4'h0, 1'b0, 3'd0, 1'b0);
    tick(1);
    chk_state("per_fire90", 4'h2, 1'b1, 3'd1, 1'b0);
    bus_wr(8'h28, 32'h0);
    bus_wr(8'h04, 32'h2);
    chk_state("per_off", 4'h0, 1'b0, 3'd0, 1'b0);

    // Channels 2 and 3 fire together; lowest index wins.
    bus_wr(8'h30, 32'd30);
    bus_wr(8'h38, 32'h5);
    bus_wr(8'h40, 32'd30);
    bus_wr(8'h48, 32'h5);
    bus_wr(8'h00, 32'd0);
    tick(30);
    chk_state("pri_pre", 4'h0, 1'b0, 3'd0, 1'b0);
    tick(1);
    chk_state("pri_both", 4'hC, 1'b1, 3'd2, 1'b0);
    bus_wr(8'h04, 32'h4);
    chk_state("pri_ch3", 4'h8, 1'b1, 3'd3, 1'b0);
    bus_wr(8'h04, 32'h8);
    chk_state("pri_none", 4'h0, 1'b0, 3'd0, 1'b0);

    // STATUS clear on the exact match cycle: set wins.
    bus_wr(8'h10, 32'd20);
    bus_wr(8'h18, 32'h5);
    bus_wr(8'h00, 32'd0);
    tick(20);
    bus_wr(8'h04, 32'h1);
    chk_state("set_wins", 4'h1, 1'b1, 3'd0, 1'b0);
    bus_wr(8'h04, 32'h1);
    chk_state("set_ack", 4'h0, 1'b0, 3'd0, 1'b0);

    // 8-bit counter build: compare wrap and 254-cycle period.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    bus_wr(8'h10, 32'h05);
    bus_wr(8'h14, 32'hFE);
    bus_wr(8'h18, 32'h3);
    bus_wr(8'h00, 32'd0);
    tick(5);
    chk_state("w8_pre", 4'h0, 1'b0, 3'd0, 1'b1);
    tick(1);
    chk_state("w8_fire", 4'h1, 1'b0, 3'd0, 1'b1);
    bus_rd("w8_cmp_wrap", 8'h10, 32'h03, 1'b1);
    bus_wr(8'h04, 32'h1);
    tick(251);
    chk_state("w8_pre2", 4'h0, 1'b0, 3'd0, 1'b1);
    tick(1);
    chk_state("w8_fire2", 4'h1, 1'b0, 3'd0, 1'b1);

    // Unmapped offset, out-of-window address, COUNT truncation and wrap.
    address = Base | 32'h0000_00F0;
    MemRead = 1'b1;
    sb_push("unmapped_rd", 32'd0);
    sb_push("unmapped_hit", 32'd1);
    #1;
    sb_pop(rd_data8);
    sb_pop(32'(hit8));
    address = 32'h1000_0010;
    sb_push("miss_rd", 32'd0);
    sb_push("miss_hit", 32'd0);
    #1;
    sb_pop(rd_data);
    sb_pop(32'(hit));
    MemRead = 1'b0;
    @(negedge clk);
    bus_wr(8'h00, 32'h1FF);
    bus_rd("w8_count_trunc", 8'h00, 32'hFF, 1'b1);
    bus_rd("w8_count_wrap", 8'h00, 32'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised memory-mapped interrupt timer for the single-cycle MIPS machine. It provides NUM_CH independent compare channels against one shared free-running cycle counter, with one-shot and periodic modes, per-channel interrupt enable, and write-1-to-clear acknowledge. It sits beside data memory on the load/store path: its address-hit output gates the data-memory read/write strobes, and its irq output drives the cp0 interrupt input.

## Interface
Parameters:
- NUM_CH, 4: number of compare channels, 1..8.
- CNT_W, 32: counter/compare/period width, 8..32.
- BASE_ADDR, 32'hFFFF0000: 256-byte-aligned base of the register window.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  32  byte address, the ALU output.
- wr_data  in  32  store data, rt value.
- MemRead  in  1  load strobe.
- MemWrite  in  1  store strobe.
- rd_data  out  32  load data; 0 unless a hit read.
- hit  out  1  address[31:8] == BASE_ADDR[31:8].
- irq  out  1  any pending channel with interrupt enabled.
- irq_id  out  3  lowest index of pending and enabled channels; 0 if none.
- pending  out  NUM_CH  raw pending flags.

## Operation
- Register map, word offsets from BASE_ADDR:
  - 0x00 COUNT: R/W.
  - 0x04 STATUS: read gives pending; a write clears each pending bit where wr_data is 1.
  - 0x08 IRQID: read-only.
  - Per channel i, at 0x10+16i: COMPARE_i (+0x0), PERIOD_i (+0x4), CTRL_i (+0x8). CTRL bit0 EN, bit1 PERIODIC, bit2 IE.
- Unmapped offsets and channels ≥ NUM_CH read 0; writes to them are ignored. Writes to IRQID are ignored.
- Address bits [1:0] are ignored.
- Reads zero-extend CNT_W values. Writes truncate to CNT_W, or to 3 bits for CTRL.
- COUNT increments by 1 every cycle and wraps modulo 2^CNT_W. A COUNT write loads wr_data in place of the increment.
- Channel i fires in a cycle when EN_i=1 and COUNT == COMPARE_i, using values before that cycle's updates. On fire:
  - pending_i is set.
  - If PERIODIC_i=1: COMPARE_i <= COMPARE_i + PERIOD_i, mod 2^CNT_W. PERIOD_i=0 therefore fires once per counter wrap.
  - If PERIODIC_i=0: EN_i is cleared.
- Fire occurs regardless of IE_i. IE only masks irq and irq_id.
- Simultaneous events:
  - Fire and STATUS clear on the same bit: set wins.
  - Fire and a software write to COMPARE_i or CTRL_i: the software write wins.
  - COUNT write and compare match: the match uses the pre-write COUNT.
- A write is effective only with MemWrite=1 and hit=1. MemRead and MemWrite asserted together is illegal; the write takes effect and rd_data is still driven.

## Timing
- rd_data, hit, irq, irq_id and pending are combinational from the current state and inputs.
- Read latency: rd_data is valid in the same cycle as MemRead.
- Write latency: one cycle; the new value is visible from the next edge.
- Fire latency: pending and irq rise one cycle after the matching COUNT value, i.e. after the edge ending the match cycle.
- Acknowledge latency: irq drops the cycle after the STATUS write, unless a re-fire occurs in that same cycle.
- Reset values: COUNT 0, every COMPARE all-ones, PERIOD 0, CTRL 0, pending 0. Resulting outputs: irq 0, irq_id 0, rd_data 0.
- Reset asserted mid-operation overrides every pending write and fire in that cycle.

## Structure
- Shared package holds:
  - register offset constants: OFF_COUNT, OFF_STATUS, OFF_IRQID, OFF_CH_BASE, CH_STRIDE, OFF_CMP, OFF_PER, OFF_CTRL;
  - CTRL bit indices: CTRL_EN, CTRL_PERIODIC, CTRL_IE.
- Sub-module timer_channel: one per channel, instantiated with a generate loop. It holds COMPARE, PERIOD, CTRL and pending, and exports fire, pending, ie and readback.
- The top level holds COUNT, address decode, the read mux and the lowest-index priority encoder.

## Test plan
- Reset, then read COUNT twice 5 cycles apart -> second read is 5 greater; irq=0, pending=0.
- Write COUNT=100, write COMPARE_0=110, write CTRL_0=0b101 -> pending[0] and irq rise exactly 11 cycles after the COUNT write edge. CTRL_0 then reads 0b100 (one-shot cleared EN).
- PERIOD_1=20, COMPARE_1=50, CTRL_1=0b111, COUNT=0 -> fires at COUNT 50, 70 and 90. Write STATUS=0x2 between fires -> irq drops one cycle later and re-rises on the next fire.
- Channels 2 and 3 fire on the same cycle, both with IE=1 -> irq_id=2. Clear bit 2 -> irq_id=3.
- Hold a STATUS write of 0x1 on the exact cycle channel 0 matches -> pending[0] stays 1.
- CNT_W=8 build: COMPARE=0x05, PERIOD=0xFE, periodic mode -> next COMPARE reads 0x03 (wrap); fires again after 254 cycles. Unmapped offset 0xF0 reads 0, and hit=1 for that address.
